// File: rtl/mul_frontend.sv
// RV32IM multiply front end: operand extension, launch, and result return for a Booth radix-4 core.
// Handles one operation at a time, with a zero-operand shortcut and a watchdog abort.
module mul_frontend #(
    parameter int XLEN    = 32,
    parameter int MW      = 34,
    parameter int TAG_W   = 5,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [XLEN-1:0]   req_rs1,
    input  logic [XLEN-1:0]   req_rs2,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    output logic              rsp_err,
    output logic              core_start,
    output logic [MW-1:0]     core_a,
    output logic [MW-1:0]     core_b,
    input  logic              core_done,
    input  logic [2*MW-1:0]   core_product
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [MW-1:0]      a_q, a_d;
    logic [MW-1:0]      b_q, b_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0]    data_q, data_d;
    logic               err_q, err_d;

    op_e                req_op_e;
    logic               a_sign;
    logic               b_sign;
    logic [MW-1:0]      a_ext;
    logic [MW-1:0]      b_ext;
    logic               zero_operand;
    logic [XLEN-1:0]    product_sel;

    // Product bits above 2*XLEN only carry sign; they are never returned.
    logic               unused_product_hi;
    assign unused_product_hi = ^core_product[2*MW-1:2*XLEN];

    assign req_op_e = op_e'(req_op);

    // rs1 is unsigned only for MULHU; rs2 is unsigned for MULHSU and MULHU.
    assign a_sign       = (req_op_e != OP_MULHU) & req_rs1[XLEN-1];
    assign b_sign       = ~req_op[1] & req_rs2[XLEN-1];
    assign a_ext        = {{(MW-XLEN){a_sign}}, req_rs1};
    assign b_ext        = {{(MW-XLEN){b_sign}}, req_rs2};
    assign zero_operand = (req_rs1 == '0) || (req_rs2 == '0);

    assign product_sel = (op_q == OP_MUL) ? core_product[XLEN-1:0]
                                          : core_product[2*XLEN-1:XLEN];

    // NOTE: every _d gets its default first, so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        tag_d   = tag_q;
        a_d     = a_q;
        b_d     = b_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        err_d   = err_q;

        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d  = req_op_e;
                    tag_d = req_tag;
                    a_d   = a_ext;
                    b_d   = b_ext;
                    if (zero_operand) begin
                        data_d  = '0;
                        err_d   = 1'b0;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_LAUNCH;
                    end
                end
            end
            S_LAUNCH: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A done in the final watchdog cycle still wins over the abort.
                if (core_done) begin
                    data_d  = product_sel;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= OP_MUL;
            tag_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE) & ~rst;
    assign core_start = (state_q == S_LAUNCH);
    assign core_a     = a_q;
    assign core_b     = b_q;
    assign rsp_valid  = (state_q == S_RESP);
    assign rsp_data   = data_q;
    assign rsp_tag    = tag_q;
    assign rsp_err    = err_q;

endmodule
